// File: rtl/seg_display_driver.sv
// -----------------------------------------------------------------------------
// seg_display_driver
//
// Segment-side driver for a 4-digit multiplexed seven-segment display. The
// active-low anode scan code from an external scan counter selects which digit
// is being shown. This block drives the matching active-low segment and
// decimal-point lines.
//
// New values arrive through a load/ready handshake into a shadow register.
// They are promoted to the displayed value only when the scan wraps to
// digit 0, so a frame never mixes old and new digits. A stall timer forces the
// promotion if the scanner stops moving.
//
// Ports
//   clk      in   system clock, rising edge
//   Reset    in   synchronous active-high reset
//   AN[3:0]  in   anode scan code, active-low one-hot, digit 0 rightmost
//   data     in   16-bit hex value, nibble i -> digit i
//   dp_mask  in   decimal points, bit i lights digit i (captured with data)
//   blank_lz in   leading-zero blanking enable (captured with data)
//   load     in   capture request
//   ready    out  a load will be accepted this cycle
//   seg[6:0] out  segments {g,f,e,d,c,b,a}, active-low, registered
//   dp       out  decimal point, active-low, registered
//   commit   out  shadow becomes the displayed value in this cycle
//   scan_err out  sticky flag for an illegal AN code
// -----------------------------------------------------------------------------
module seg_display_driver #(
    parameter int STALL_LIMIT = 400000
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic [3:0]  AN,
    input  logic [15:0] data,
    input  logic [3:0]  dp_mask,
    input  logic        blank_lz,
    input  logic        load,
    output logic        ready,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        commit,
    output logic        scan_err
);

    localparam int CW = $clog2(STALL_LIMIT);
    localparam logic [CW-1:0] STALL_MAX = CW'(STALL_LIMIT - 1);

    typedef enum logic {S_IDLE, S_PENDING} state_t;

    state_t         r_state;
    logic [15:0]    r_sh_data;
    logic [3:0]     r_sh_dp;
    logic           r_sh_blz;
    logic [15:0]    r_disp_data;
    logic [3:0]     r_disp_dp;
    logic           r_disp_blz;
    logic [3:0]     r_an_q;
    logic [CW-1:0]  r_stall_cnt;
    logic [6:0]     r_seg;
    logic           r_dp;
    logic           r_scan_err;

    logic           w_boundary;
    logic           w_timeout;
    logic           w_commit;
    logic [15:0]    w_src_data;
    logic [3:0]     w_src_dp;
    logic           w_src_blz;
    logic [3:0]     w_sel;
    logic [3:0]     w_blank;
    logic [3:1]     w_nz;
    logic           w_valid;
    logic           w_illegal;
    logic [1:0]     w_idx;
    logic [3:0]     w_nib;
    logic [6:0]     w_hex;

    // The scan wrapping onto digit 0 marks the start of a new frame.
    assign w_boundary = (AN == 4'b1110) && (r_an_q != 4'b1110);
    assign w_timeout  = (r_stall_cnt == STALL_MAX);
    // Reset discards a pending value, so it must never pulse commit.
    assign w_commit   = (r_state == S_PENDING) && (w_boundary || w_timeout) && !Reset;

    // In a commit cycle, decode from the shadow so digit 0 of the new frame
    // already shows the new value.
    assign w_src_data = w_commit ? r_sh_data : r_disp_data;
    assign w_src_dp   = w_commit ? r_sh_dp   : r_disp_dp;
    assign w_src_blz  = w_commit ? r_sh_blz  : r_disp_blz;

    // Per-digit select and leading-zero blanking. Digit i is blank when it and
    // every digit to its left are zero. Digit 0 always shows.
    assign w_blank[0] = 1'b0;
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_sel
            assign w_sel[gi] = (AN == ~(4'b0001 << gi));
        end
        for (genvar gi = 1; gi < 4; gi++) begin : g_lz
            assign w_nz[gi]    = |w_src_data[4*gi +: 4];
            assign w_blank[gi] = w_src_blz && ~|w_nz[3:gi];
        end
    endgenerate

    assign w_valid   = |w_sel;
    // 1111 (all off) and 0000 (scanner in reset) blank quietly.
    assign w_illegal = !w_valid && (AN != 4'b1111) && (AN != 4'b0000);

    always_comb begin
        w_idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (w_sel[i]) w_idx = 2'(i);
        end
    end

    assign w_nib = w_src_data[{w_idx, 2'b00} +: 4];

    always_comb begin
        w_hex = 7'b1111111;
        case (w_nib)
            4'h0: w_hex = 7'b1000000;
            4'h1: w_hex = 7'b1111001;
            4'h2: w_hex = 7'b0100100;
            4'h3: w_hex = 7'b0110000;
            4'h4: w_hex = 7'b0011001;
            4'h5: w_hex = 7'b0010010;
            4'h6: w_hex = 7'b0000010;
            4'h7: w_hex = 7'b1111000;
            4'h8: w_hex = 7'b0000000;
            4'h9: w_hex = 7'b0010000;
            4'hA: w_hex = 7'b0001000;
            4'hB: w_hex = 7'b0000011;
            4'hC: w_hex = 7'b1000110;
            4'hD: w_hex = 7'b0100001;
            4'hE: w_hex = 7'b0000110;
            4'hF: w_hex = 7'b0001110;
            default: w_hex = 7'b1111111;
        endcase
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            r_state     <= S_IDLE;
            r_sh_data   <= '0;
            r_sh_dp     <= '0;
            r_sh_blz    <= 1'b0;
            r_disp_data <= '0;
            r_disp_dp   <= '0;
            r_disp_blz  <= 1'b0;
            r_an_q      <= 4'b1111;
            r_stall_cnt <= '0;
            r_seg       <= 7'b1111111;
            r_dp        <= 1'b1;
            r_scan_err  <= 1'b0;
        end else begin
            r_an_q <= AN;

            // Measures how long the scan code has been frozen while pending.
            if (r_state == S_IDLE || AN != r_an_q)
                r_stall_cnt <= '0;
            else
                r_stall_cnt <= r_stall_cnt + 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (load) begin
                        r_sh_data <= data;
                        r_sh_dp   <= dp_mask;
                        r_sh_blz  <= blank_lz;
                        r_state   <= S_PENDING;
                    end
                end
                S_PENDING: begin
                    if (w_commit) begin
                        r_disp_data <= r_sh_data;
                        r_disp_dp   <= r_sh_dp;
                        r_disp_blz  <= r_sh_blz;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_valid) begin
                r_seg <= w_blank[w_idx] ? 7'b1111111 : w_hex;
                r_dp  <= ~w_src_dp[w_idx];
            end else begin
                r_seg <= 7'b1111111;
                r_dp  <= 1'b1;
            end

            if (w_illegal) r_scan_err <= 1'b1;
        end
    end

    assign ready    = (r_state == S_IDLE);
    assign commit   = w_commit;
    assign seg      = r_seg;
    assign dp       = r_dp;
    assign scan_err = r_scan_err;

endmodule

// File: tb/tb_seg_display_driver.sv
module tb_seg_display_driver;

    localparam int STALL_LIMIT = 8;
    localparam logic [3:0] SCAN [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    logic        clk = 1'b0;
    logic        Reset;
    logic [3:0]  AN;
    logic [15:0] data;
    logic [3:0]  dp_mask;
    logic        blank_lz;
    logic        load;
    logic        ready;
    logic [6:0]  seg;
    logic        dp;
    logic        commit;
    logic        scan_err;

    // Values seen just before the edge (combinational) and just after it.
    logic        p_commit, p_ready;
    logic [6:0]  s_seg;
    logic        s_dp, s_err, s_ready;

    int n_assert = 0;
    int n_fail   = 0;

    seg_display_driver #(.STALL_LIMIT(STALL_LIMIT)) dut (
        .clk      (clk),
        .Reset    (Reset),
        .AN       (AN),
        .data     (data),
        .dp_mask  (dp_mask),
        .blank_lz (blank_lz),
        .load     (load),
        .ready    (ready),
        .seg      (seg),
        .dp       (dp),
        .commit   (commit),
        .scan_err (scan_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("check %-14s observed %h expected %h", tag, obs, exp);
    endtask

    // One clock cycle: drive AN/load, sample combinational outputs before the
    // edge and registered outputs after it.
    task automatic cyc(input logic [3:0] an, input logic ld);
        @(negedge clk);
        AN   = an;
        load = ld;
        #1;
        p_commit = commit;
        p_ready  = ready;
        @(posedge clk);
        #1;
        s_seg   = seg;
        s_dp    = dp;
        s_err   = scan_err;
        s_ready = ready;
        load    = 1'b0;
    endtask

    initial begin
        Reset = 1'b1; AN = 4'b1111; data = '0; dp_mask = '0; blank_lz = 1'b0; load = 1'b0;

        // Reset state
        cyc(4'b1111, 1'b0);
        cyc(4'b1111, 1'b0);
        chk("rst_seg",    16'(s_seg), 16'h7F);
        chk("rst_dp",     16'(s_dp),  16'h1);
        chk("rst_ready",  16'(s_ready), 16'h1);
        chk("rst_err",    16'(s_err), 16'h0);
        Reset = 1'b0;
        cyc(4'b1111, 1'b0);
        chk("rst_commit", 16'(p_commit), 16'h0);

        // Scan with zero display
        for (int d = 0; d < 4; d++) begin
            cyc(SCAN[d], 1'b0);
            chk("zero_seg", 16'(s_seg), 16'h40);
            chk("zero_dp",  16'(s_dp),  16'h1);
        end

        // Load 1A2F mid-frame at digit 1
        data = 16'h1A2F; dp_mask = 4'b0000; blank_lz = 1'b0;
        cyc(4'b1110, 1'b0);
        cyc(4'b1101, 1'b1);
        chk("ld_ready_pre", 16'(p_ready), 16'h1);
        chk("ld_ready_post", 16'(s_ready), 16'h0);
        chk("ld_old_d1", 16'(s_seg), 16'h40);
        cyc(4'b1011, 1'b0);
        chk("ld_nocommit", 16'(p_commit), 16'h0);
        chk("ld_old_d2", 16'(s_seg), 16'h40);
        cyc(4'b0111, 1'b0);
        chk("ld_old_d3", 16'(s_seg), 16'h40);
        cyc(4'b1110, 1'b0);
        chk("ld_commit", 16'(p_commit), 16'h1);
        chk("ld_d0_F", 16'(s_seg), 16'h0E);
        chk("ld_ready_back", 16'(s_ready), 16'h1);
        cyc(4'b1101, 1'b0);
        chk("ld_commit_off", 16'(p_commit), 16'h0);
        chk("ld_d1_2", 16'(s_seg), 16'h24);
        cyc(4'b1011, 1'b0);
        chk("ld_d2_A", 16'(s_seg), 16'h08);
        cyc(4'b0111, 1'b0);
        chk("ld_d3_1", 16'(s_seg), 16'h79);
        chk("ld_dp", 16'(s_dp), 16'h1);

        // Leading-zero blanking: 0030, dp on digit 3
        data = 16'h0030; dp_mask = 4'b1000; blank_lz = 1'b1;
        cyc(4'b1110, 1'b0);
        cyc(4'b1101, 1'b1);
        chk("lz_old_d1", 16'(s_seg), 16'h24);
        cyc(4'b1011, 1'b0);
        cyc(4'b0111, 1'b0);
        chk("lz_old_d3", 16'(s_seg), 16'h79);
        cyc(4'b1110, 1'b0);
        chk("lz_commit", 16'(p_commit), 16'h1);
        chk("lz_d0_seg", 16'(s_seg), 16'h40);
        chk("lz_d0_dp",  16'(s_dp),  16'h1);
        cyc(4'b1101, 1'b0);
        chk("lz_d1_seg", 16'(s_seg), 16'h30);
        cyc(4'b1011, 1'b0);
        chk("lz_d2_seg", 16'(s_seg), 16'h7F);
        chk("lz_d2_dp",  16'(s_dp),  16'h1);
        cyc(4'b0111, 1'b0);
        chk("lz_d3_seg", 16'(s_seg), 16'h7F);
        chk("lz_d3_dp",  16'(s_dp),  16'h0);

        // Stalled scanner held at 0000: commit exactly STALL_LIMIT cycles on
        data = 16'h8888; dp_mask = 4'b0000; blank_lz = 1'b0;
        cyc(4'b0000, 1'b0);
        chk("st_seg0", 16'(s_seg), 16'h7F);
        chk("st_err0", 16'(s_err), 16'h0);
        cyc(4'b0000, 1'b1);
        chk("st_accept", 16'(p_ready), 16'h1);
        for (int k = 1; k <= STALL_LIMIT; k++) begin
            cyc(4'b0000, 1'b0);
            chk("st_commit", 16'(p_commit), 16'((k == STALL_LIMIT) ? 1 : 0));
            chk("st_seg", 16'(s_seg), 16'h7F);
        end
        chk("st_ready", 16'(s_ready), 16'h1);
        cyc(4'b1110, 1'b0);
        chk("st_d0_8", 16'(s_seg), 16'h00);
        chk("st_nocommit", 16'(p_commit), 16'h0);

        // Illegal scan code sets a sticky error
        cyc(4'b1100, 1'b0);
        chk("ill_err", 16'(s_err), 16'h1);
        chk("ill_seg", 16'(s_seg), 16'h7F);
        chk("ill_dp",  16'(s_dp),  16'h1);
        for (int d = 1; d < 4; d++) begin
            cyc(SCAN[d], 1'b0);
            chk("ill_sticky", 16'(s_err), 16'h1);
            chk("ill_scan_seg", 16'(s_seg), 16'h00);
        end
        cyc(4'b1110, 1'b0);
        chk("ill_sticky", 16'(s_err), 16'h1);

        // Reset while pending discards the value
        data = 16'h1234; dp_mask = 4'b1111; blank_lz = 1'b0;
        cyc(4'b1101, 1'b1);
        chk("rp_pending", 16'(s_ready), 16'h0);
        Reset = 1'b1;
        cyc(4'b1011, 1'b0);
        chk("rp_commit", 16'(p_commit), 16'h0);
        chk("rp_ready", 16'(s_ready), 16'h1);
        chk("rp_err_clr", 16'(s_err), 16'h0);
        Reset = 1'b0;
        cyc(4'b0111, 1'b0);
        chk("rp_d3", 16'(s_seg), 16'h40);
        cyc(4'b1110, 1'b0);
        chk("rp_commit2", 16'(p_commit), 16'h0);
        chk("rp_d0", 16'(s_seg), 16'h40);
        chk("rp_dp", 16'(s_dp), 16'h1);
        cyc(4'b1101, 1'b0);
        cyc(4'b1011, 1'b0);
        cyc(4'b0111, 1'b0);

        // Load at a boundary in IDLE commits on the following boundary
        data = 16'h00E5; dp_mask = 4'b0001; blank_lz = 1'b0;
        cyc(4'b1110, 1'b1);
        chk("cb_ready", 16'(p_ready), 16'h1);
        chk("cb_commit0", 16'(p_commit), 16'h0);
        chk("cb_d0_old", 16'(s_seg), 16'h40);
        for (int d = 1; d < 4; d++) begin
            cyc(SCAN[d], 1'b0);
            chk("cb_commit_n", 16'(p_commit), 16'h0);
            chk("cb_old", 16'(s_seg), 16'h40);
        end
        cyc(4'b1110, 1'b0);
        chk("cb_commit1", 16'(p_commit), 16'h1);
        chk("cb_d0_5", 16'(s_seg), 16'h12);
        chk("cb_d0_dp", 16'(s_dp), 16'h0);
        cyc(4'b1101, 1'b0);
        chk("cb_d1_E", 16'(s_seg), 16'h06);
        chk("cb_d1_dp", 16'(s_dp), 16'h1);
        cyc(4'b1011, 1'b0);
        chk("cb_d2_0", 16'(s_seg), 16'h40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
